// File: rtl/pwm_duty_bank_if.sv
// Write/commit bus and duty-value outputs of pwm_duty_bank, bundled for
// the port list.
interface pwm_duty_bank_if #(
  parameter int CH = 4,
  parameter int W  = 8
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic              wr_en;
  logic [CW-1:0]     wr_ch;
  logic [W-1:0]      wr_data;
  logic              commit;
  logic              freeze;
  logic [CH*W-1:0]   duty_out;
  logic [CH-1:0]     pending;
  logic              upd_pulse;
  logic              wr_err;

  modport master (
    output wr_en, wr_ch, wr_data, commit, freeze,
    input  duty_out, pending, upd_pulse, wr_err
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, commit, freeze,
    output duty_out, pending, upd_pulse, wr_err
  );
endinterface

// File: rtl/pwm_duty_bank.sv
// Double-buffered bank of PWM duty words. Shadows take writes at any time.
// Active values swap in on a period-boundary commit and then run through a
// fixed-latency output pipeline.
module pwm_duty_lane #(
  parameter int            W       = 8,
  parameter int            PIPE    = 2,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          wr_sel,
  input  logic [W-1:0]  wr_data,
  input  logic          commit_ok,
  output logic [W-1:0]  duty,
  output logic          pend
);
  logic [W-1:0]            shadow_q, shadow_d;
  logic                    pend_q, pend_d;
  logic [PIPE-1:0][W-1:0]  pipe_q, pipe_d;   // stage 0 is the active register

  always_comb begin
    shadow_d = wr_sel ? wr_data : shadow_q;
    pend_d   = pend_q;
    if (commit_ok) pend_d = 1'b0;
    // A write in the commit cycle re-arms pending for the next period.
    if (wr_sel)    pend_d = 1'b1;
    pipe_d[0] = (commit_ok && pend_q) ? shadow_q : pipe_q[0];
    for (int k = 1; k < PIPE; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      shadow_q <= RST_VAL;
      pend_q   <= 1'b0;
      pipe_q   <= {PIPE{RST_VAL}};
    end else begin
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pipe_q   <= pipe_d;
    end
  end

  assign duty = pipe_q[PIPE-1];
  assign pend = pend_q;
endmodule

module pwm_duty_bank #(
  parameter int            CH      = 4,
  parameter int            W       = 8,
  parameter int            PIPE    = 2,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic            ck,
  input  logic            rst,
  pwm_duty_bank_if.slave  bus
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]          wr_sel;
  logic                   wr_bad;
  logic                   commit_ok;
  logic [CH-1:0]          pend;
  logic [CH-1:0][W-1:0]   duty;
  logic [PIPE-1:0]        vld_pipe_q, vld_pipe_d;
  logic                   wr_err_q, wr_err_d;

  always_comb begin
    for (int i = 0; i < CH; i++) wr_sel[i] = bus.wr_en && (bus.wr_ch == CW'(i));
    // No lane matched: the index is out of range.
    wr_bad    = bus.wr_en && ~|wr_sel;
    commit_ok = bus.commit && !bus.freeze;
    vld_pipe_d[0] = commit_ok && |pend;
    for (int k = 1; k < PIPE; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    wr_err_d  = wr_err_q | wr_bad;
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      wr_err_q   <= wr_err_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    pwm_duty_lane #(.W(W), .PIPE(PIPE), .RST_VAL(RST_VAL)) u_lane (
      .ck        (ck),
      .rst       (rst),
      .wr_sel    (wr_sel[g]),
      .wr_data   (bus.wr_data),
      .commit_ok (commit_ok),
      .duty      (duty[g]),
      .pend      (pend[g])
    );
  end

  assign bus.duty_out  = duty;
  assign bus.pending   = pend;
  assign bus.upd_pulse = vld_pipe_q[PIPE-1];
  assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_pwm_duty_bank.sv
// Directed bench for pwm_duty_bank: a 4-channel bank for the main function
// and a 3-channel bank for out-of-range writes.
module tb_pwm_duty_bank;
  logic ck = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 ck = ~ck;

  pwm_duty_bank_if #(.CH(4), .W(8)) b4 ();
  pwm_duty_bank_if #(.CH(3), .W(8)) b3 ();

  pwm_duty_bank #(.CH(4), .W(8), .PIPE(2), .RST_VAL(8'h00)) dut4 (
    .ck(ck), .rst(rst), .bus(b4));
  pwm_duty_bank #(.CH(3), .W(8), .PIPE(2), .RST_VAL(8'h00)) dut3 (
    .ck(ck), .rst(rst), .bus(b3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    b4.wr_en = 0; b4.wr_ch = '0; b4.wr_data = '0; b4.commit = 0; b4.freeze = 0;
    b3.wr_en = 0; b3.wr_ch = '0; b3.wr_data = '0; b3.commit = 0; b3.freeze = 0;

    // Asynchronous reset mid-cycle, checked before any clock edge
    #12 rst = 1'b1;
    #1;
    chk("rst_duty",    b4.duty_out,  32'h0);
    chk("rst_pending", b4.pending,   4'b0);
    chk("rst_upd",     b4.upd_pulse, 1'b0);
    chk("rst_wr_err",  b4.wr_err,    1'b0);
    tick();
    rst = 1'b0;

    // Basic commit on ch2
    b4.wr_en = 1; b4.wr_ch = 2'd2; b4.wr_data = 8'h80;
    tick();
    b4.wr_en = 0;
    chk("basic_pending", b4.pending, 4'b0100);
    chk("basic_duty0",   b4.duty_out, 32'h0);
    b4.commit = 1;
    tick();
    b4.commit = 0;
    chk("basic_pend_clr", b4.pending, 4'b0000);
    chk("basic_lat1",     b4.duty_out, 32'h0);
    chk("basic_upd_lat1", b4.upd_pulse, 1'b0);
    tick();
    chk("basic_duty",  b4.duty_out, 32'h0080_0000);
    chk("basic_upd",   b4.upd_pulse, 1'b1);
    tick();
    chk("basic_upd_off", b4.upd_pulse, 1'b0);
    chk("basic_hold",    b4.duty_out, 32'h0080_0000);

    // Write and commit to ch1 in the same cycle
    b4.wr_en = 1; b4.wr_ch = 2'd1; b4.wr_data = 8'h10;
    tick();
    b4.wr_data = 8'h20; b4.commit = 1;
    tick();
    b4.wr_en = 0; b4.commit = 0;
    chk("same_pending", b4.pending, 4'b0010);
    tick();
    chk("same_duty_old", b4.duty_out, 32'h0080_1000);
    chk("same_upd",      b4.upd_pulse, 1'b1);
    b4.commit = 1;
    tick();
    b4.commit = 0;
    tick();
    chk("same_duty_new", b4.duty_out, 32'h0080_2000);
    chk("same_upd2",     b4.upd_pulse, 1'b1);
    chk("same_pend_clr", b4.pending, 4'b0000);

    // Commit under freeze is dropped
    b4.wr_en = 1; b4.wr_ch = 2'd0; b4.wr_data = 8'h55;
    tick();
    b4.wr_en = 0;
    b4.commit = 1; b4.freeze = 1;
    tick();
    b4.commit = 0; b4.freeze = 0;
    chk("frz_pending", b4.pending, 4'b0001);
    tick();
    chk("frz_upd",  b4.upd_pulse, 1'b0);
    chk("frz_duty", b4.duty_out, 32'h0080_2000);
    b4.commit = 1;
    tick();
    b4.commit = 0;
    tick();
    chk("frz_duty_after", b4.duty_out, 32'h0080_2055);
    chk("frz_upd_after",  b4.upd_pulse, 1'b1);
    chk("frz_pend_clr",   b4.pending, 4'b0000);

    // Commit with nothing pending
    b4.commit = 1;
    tick();
    b4.commit = 0;
    tick();
    chk("empty_upd",  b4.upd_pulse, 1'b0);
    chk("empty_duty", b4.duty_out, 32'h0080_2055);

    // Out-of-range write on the 3-channel bank
    b3.wr_en = 1; b3.wr_ch = 2'd3; b3.wr_data = 8'hFF;
    tick();
    b3.wr_en = 0;
    chk("inv_pending", b3.pending, 3'b000);
    chk("inv_err",     b3.wr_err, 1'b1);
    chk("inv_other",   b4.wr_err, 1'b0);
    b3.commit = 1;
    tick();
    tick();
    b3.commit = 0;
    tick();
    chk("inv_err_sticky", b3.wr_err, 1'b1);
    chk("inv_duty",       b3.duty_out, 24'h0);
    chk("inv_upd",        b3.upd_pulse, 1'b0);

    // Reset while a commit is in flight
    b4.wr_en = 1; b4.wr_ch = 2'd3; b4.wr_data = 8'hAA;
    tick();
    b4.wr_en = 0;
    b4.commit = 1;
    tick();
    b4.commit = 0;
    #3 rst = 1'b1;
    #1;
    chk("mid_duty",    b4.duty_out, 32'h0);
    chk("mid_upd",     b4.upd_pulse, 1'b0);
    chk("mid_pending", b4.pending, 4'b0);
    chk("mid_err3",    b3.wr_err, 1'b0);
    tick();
    chk("mid_upd_hold", b4.upd_pulse, 1'b0);
    rst = 1'b0;
    tick();
    chk("mid_upd_rel",  b4.upd_pulse, 1'b0);
    tick();
    chk("mid_duty_rel", b4.duty_out, 32'h0);
    chk("mid_upd_rel2", b4.upd_pulse, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_duty_bank.md
Name: pwm_duty_bank

Overview:
- Multi-channel, parametrised successor to the single-bit D flip-flop used in the PWM path.
- Holds CH duty-cycle words of W bits each, with double buffering: a shadow register per channel takes writes at any time, and an active register per channel updates only on a period-boundary commit. This keeps each PWM period glitch-free.
- The active values pass through a configurable output pipeline to the PWM comparators.

Parameters:
- CH, 4, number of channels (>=1).
- W, 8, duty word width in bits (>=1).
- PIPE, 2, output latency in register stages from active register to duty_out (>=1; the active register counts as stage 1).
- RST_VAL, 0, W-bit value loaded into every shadow, active and pipeline register on reset.

Ports:
- ck  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the shadow register selected by wr_ch.
- wr_ch  in  max(1,clog2(CH))  channel index for the write.
- wr_data  in  W  duty value to write.
- commit  in  1  single-cycle period-boundary pulse from the PWM counter.
- freeze  in  1  when high, commits are ignored and active values are held.
- duty_out  out  CH*W  active duty values after the pipeline; channel i occupies bits [i*W +: W].
- pending  out  CH  bit i high means shadow i was written since its last commit.
- upd_pulse  out  1  one-cycle pulse aligned with the first cycle duty_out shows committed data.
- wr_err  out  1  sticky flag: a write targeted wr_ch >= CH.

Behaviour:
- Reset (async, immediate):
  - shadow, active and pipeline registers = RST_VAL.
  - pending = 0, upd_pulse = 0, wr_err = 0.
  - Deassertion is sampled on ck; the first operation takes effect on the first rising edge with rst low.
- Write: wr_en=1 and wr_ch<CH at an edge → shadow[wr_ch] <= wr_data, pending[wr_ch] <= 1. A write to a channel already pending overwrites it; last write wins.
- Invalid write: wr_en=1 and wr_ch>=CH → no shadow or pending change; wr_err <= 1. wr_err stays set until rst.
- Commit: commit=1 and freeze=0 at an edge → for every i with pending[i]=1, active[i] <= shadow[i] and pending[i] <= 0. Channels that are not pending keep their active value.
- Simultaneous write and commit to the same channel:
  - The commit uses the pre-edge shadow value.
  - The new wr_data lands in the shadow.
  - pending[ch] ends at 1, so the new value goes out on the next commit.
- Commit with freeze=1: ignored; shadow and pending are unchanged. Commits are not queued for later.
- Commit with no channel pending: active is unchanged and upd_pulse is not generated.
- Pipeline:
  - active feeds PIPE-1 further register stages; duty_out = last stage.
  - With PIPE=1, duty_out = active.
  - Latency from the commit edge to duty_out change is PIPE cycles, counting the commit edge as cycle 1.
  - All channels advance in lockstep and there are no bubbles.
- upd_pulse: a 1-bit flag, set on a commit that updated at least one channel, delayed through the same PIPE stages. It is high exactly in the cycle duty_out first shows the new values.
- Back-to-back commits on consecutive cycles: each is processed independently, and each updating commit yields its own upd_pulse.
- Reset mid-pipeline: all in-flight values are discarded; duty_out = RST_VAL on every channel.
- Arithmetic: no arithmetic; values are stored unmodified; no saturation.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle (CH=4, W=8, PIPE=2, RST_VAL=0) → duty_out=0 immediately; pending=0, upd_pulse=0, wr_err=0.
- Basic commit: write ch2=0x80 → pending=4'b0100; commit → duty_out[23:16]=0x80 exactly 2 cycles later; upd_pulse is a single pulse in that cycle; pending=0; other channels stay 0.
- Same-cycle write and commit: write ch1=0x10, then in the commit cycle write ch1=0x20 → duty_out ch1=0x10 and pending[1]=1; after the second commit, ch1=0x20.
- Freeze: write ch0=0x55, commit with freeze=1 → duty_out unchanged, pending[0]=1, no upd_pulse; later commit with freeze=0 → ch0=0x55 after 2 cycles.
- Invalid channel: build with CH=3, write wr_ch=3 data 0xFF → no pending bit set, wr_err=1 and still 1 after two commits; cleared only by rst.
- Empty commit and reset mid-flight: commit with pending=0 → no upd_pulse. Write ch3=0xAA, commit, assert rst 1 cycle later → duty_out ch3 stays 0 and upd_pulse never asserts.
